// File: rtl/edge_det_bank_pkg.sv
// Shared types and helpers for the edge detector bank.
package edge_det_bank_pkg;

  // Classification of what the filtered state does on the current edge
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_kind_t;

  // Mismatch counter width: ceil(log2(filt+1)), never below one bit
  function automatic int cnt_width(input int filt);
    int w;
    w = $clog2(filt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, glitch filter, edge pulses and sticky pend flag.
module edge_det_chan
  import edge_det_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic i,
  input  logic rise_en,
  input  logic fall_en,
  input  logic clr,
  output logic pe,
  output logic ne,
  output logic ee,
  output logic pend
);

  localparam int              CW      = cnt_width(FILT_CNT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_CNT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_st;
  logic [CW-1:0]          r_cnt;
  logic                   r_pe;
  logic                   r_ne;
  logic                   r_ee;
  logic                   r_pend;
  logic                   w_s;
  logic                   w_set;
  edge_kind_t             w_edge;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain, runs every clock independent of ce
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i};
  end

  // Decide whether the filtered state flips on this edge, and which way
  always_comb begin
    w_edge = EDGE_NONE;
    if (ce && (w_s != r_st) && (r_cnt == CNT_MAX))
      w_edge = w_s ? EDGE_RISE : EDGE_FALL;
  end

  // Mismatch counter and filtered state; counter saturates at CNT_MAX by flipping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= 1'b0;
      r_cnt <= '0;
    end else if (ce) begin
      if (w_s == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_st  <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // One-clock edge pulses registered on the flip edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pe <= 1'b0;
      r_ne <= 1'b0;
      r_ee <= 1'b0;
    end else begin
      r_pe <= (w_edge == EDGE_RISE);
      r_ne <= (w_edge == EDGE_FALL);
      r_ee <= (w_edge != EDGE_NONE);
    end
  end

  assign w_set = ((w_edge == EDGE_RISE) && rise_en) ||
                 ((w_edge == EDGE_FALL) && fall_en);

  // Sticky pend flag: a new qualified edge wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)        r_pend <= 1'b0;
    else if (w_set) r_pend <= 1'b1;
    else if (clr)   r_pend <= 1'b0;
  end

  assign pe   = r_pe;
  assign ne   = r_ne;
  assign ee   = r_ee;
  assign pend = r_pend;

endmodule

// File: rtl/edge_det_bank.sv
// Bank of independent edge-detect channels with a combined interrupt.
module edge_det_bank
  import edge_det_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] pe,
  output logic [WIDTH-1:0] ne,
  output logic [WIDTH-1:0] ee,
  output logic [WIDTH-1:0] pend,
  output logic             irq
);

  logic [WIDTH-1:0] w_pend;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT    (FILT_CNT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .i       (i[g]),
      .rise_en (rise_en[g]),
      .fall_en (fall_en[g]),
      .clr     (clr[g]),
      .pe      (pe[g]),
      .ne      (ne[g]),
      .ee      (ee[g]),
      .pend    (w_pend[g])
    );
  end

  assign pend = w_pend;
  assign irq  = |w_pend;

endmodule

// File: tb/tb_edge_det_bank.sv
// Self-checking bench for edge_det_bank (4 channels, 2 sync stages, filter 3).
module tb_edge_det_bank;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int FILT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce  = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] rise_en = '0;
  logic [W-1:0] fall_en = '0;
  logic [W-1:0] clr = '0;
  logic [W-1:0] pe, ne, ee, pend;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  edge_det_bank #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC),
    .FILT_CNT    (FILT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .i       (din),
    .rise_en (rise_en),
    .fall_en (fall_en),
    .clr     (clr),
    .pe      (pe),
    .ne      (ne),
    .ee      (ee),
    .pend    (pend),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: input history indexed by edge number, the synchronised
  // value is simply the input seen SYNC edges ago (zero if a reset intervened),
  // and the filter is a run length of consecutive mismatching ce edges.
  logic [W-1:0] hist[$];
  int           edge_k   = 0;
  int           last_rst = 0;
  logic [W-1:0] m_st     = '0;
  int           m_run[W];
  logic [W-1:0] m_pe = '0, m_ne = '0, m_ee = '0, m_pend = '0;
  logic         m_irq = 1'b0;

  task automatic model_edge();
    logic [W-1:0] past;
    logic         s;
    logic         flip;
    hist.push_back(rst ? '0 : din);
    if (rst) begin
      last_rst = edge_k;
      m_st = '0; m_pe = '0; m_ne = '0; m_ee = '0; m_pend = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
    end else begin
      past = (edge_k - SYNC > last_rst) ? hist[edge_k - SYNC] : '0;
      for (int c = 0; c < W; c++) begin
        s = past[c];
        flip = 1'b0;
        if (ce) begin
          if (s == m_st[c]) m_run[c] = 0;
          else begin
            m_run[c] = m_run[c] + 1;
            if (m_run[c] > FILT) begin
              flip = 1'b1;
              m_run[c] = 0;
            end
          end
        end
        m_pe[c] = flip & s;
        m_ne[c] = flip & ~s;
        m_ee[c] = flip;
        if (flip) m_st[c] = s;
        if ((m_pe[c] & rise_en[c]) | (m_ne[c] & fall_en[c])) m_pend[c] = 1'b1;
        else if (clr[c]) m_pend[c] = 1'b0;
      end
    end
    m_irq = |m_pend;
    edge_k++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; din = 4'b1111;
    rise_en = '1; fall_en = '1; clr = '0;
    tick(); tick();
    n_vec++;
    if ({pe, ne, ee, pend, irq} !== 17'd0) begin
      n_err++;
      $display("FAIL reset got=%h exp=0", {pe, ne, ee, pend, irq});
    end
    n_vec++;
    if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
      n_err++;
      $display("FAIL reset_model got=%h exp=%h", {pe, ne, ee, pend, irq},
               {m_pe, m_ne, m_ee, m_pend, m_irq});
    end
    rst = 1'b0; din = '0;
  endtask

  task automatic test_rise_latency();
    logic exp_p;
    do_reset();
    ce = 1'b1; rise_en = 4'b0001; fall_en = '0; clr = '0; din = '0;
    tick();
    din = 4'b0001;
    for (int j = 0; j <= 7; j++) begin
      tick();
      exp_p = (j == 5);
      n_vec++;
      if (pe[0] !== exp_p || ee[0] !== exp_p || pend[0] !== (j >= 5) || irq !== (j >= 5)) begin
        n_err++;
        $display("FAIL rise_latency E0+%0d got pe=%b ee=%b pend=%b irq=%b exp pe=%b pend=%b",
                 j, pe[0], ee[0], pend[0], irq, exp_p, (j >= 5));
      end
      n_vec++;
      if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL rise_model E0+%0d got=%h exp=%h", j, {pe, ne, ee, pend, irq},
                 {m_pe, m_ne, m_ee, m_pend, m_irq});
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    ce = 1'b1; rise_en = 4'b0010; fall_en = 4'b0010; clr = '0;
    for (int j = 0; j < 12; j++) begin
      din = (j < 3) ? 4'b0010 : 4'b0000;
      tick();
      n_vec++;
      if ({pe[1], ne[1], pend[1]} !== 3'b000) begin
        n_err++;
        $display("FAIL glitch cyc=%0d got pe/ne/pend=%b exp=000", j, {pe[1], ne[1], pend[1]});
      end
      n_vec++;
      if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL glitch_model cyc=%0d got=%h exp=%h", j, {pe, ne, ee, pend, irq},
                 {m_pe, m_ne, m_ee, m_pend, m_irq});
      end
    end
  endtask

  task automatic test_fall_disabled();
    int ne_cnt;
    do_reset();
    ce = 1'b1; rise_en = '0; fall_en = '0; clr = '0;
    din = 4'b0100;
    for (int j = 0; j < 8; j++) tick();
    din = 4'b0000;
    ne_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (ne[2] === 1'b1) ne_cnt++;
      n_vec++;
      if (pend[2] !== 1'b0 || irq !== 1'b0) begin
        n_err++;
        $display("FAIL fall_disabled cyc=%0d got pend=%b irq=%b exp 0", j, pend[2], irq);
      end
      n_vec++;
      if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL fall_model cyc=%0d got=%h exp=%h", j, {pe, ne, ee, pend, irq},
                 {m_pe, m_ne, m_ee, m_pend, m_irq});
      end
    end
    n_vec++;
    if (ne_cnt !== 1) begin
      n_err++;
      $display("FAIL fall_pulse_width got=%0d cycles exp=1", ne_cnt);
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    ce = 1'b1; rise_en = 4'b0001; fall_en = '0; clr = '0;
    din = 4'b0001;
    for (int j = 0; j < 7; j++) tick();
    din = 4'b0000;
    for (int j = 0; j < 7; j++) tick();
    din = 4'b0001;
    for (int j = 0; j < 5; j++) tick();
    clr = 4'b0001;
    tick();
    n_vec++;
    if (pe[0] !== 1'b1 || pend[0] !== 1'b1 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL clr_collision got pe=%b pend=%b irq=%b exp 1 1 1", pe[0], pend[0], irq);
    end
    tick();
    n_vec++;
    if (pend[0] !== 1'b0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL clr_alone got pend=%b irq=%b exp 0 0", pend[0], irq);
    end
    n_vec++;
    if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
      n_err++;
      $display("FAIL clr_model got=%h exp=%h", {pe, ne, ee, pend, irq},
               {m_pe, m_ne, m_ee, m_pend, m_irq});
    end
    clr = '0;
  endtask

  task automatic test_ce_toggle();
    int pe_cnt;
    do_reset();
    rise_en = 4'b1000; fall_en = '0; clr = '0;
    din = 4'b1000;
    pe_cnt = 0;
    for (int j = 0; j < 16; j++) begin
      ce = (j % 2 == 0);
      tick();
      if (pe[3] === 1'b1) pe_cnt++;
      n_vec++;
      if (pe[3] !== (j == 8)) begin
        n_err++;
        $display("FAIL ce_toggle cyc=%0d got pe3=%b exp=%b", j, pe[3], (j == 8));
      end
      n_vec++;
      if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL ce_model cyc=%0d got=%h exp=%h", j, {pe, ne, ee, pend, irq},
                 {m_pe, m_ne, m_ee, m_pend, m_irq});
      end
    end
    n_vec++;
    if (pe_cnt !== 1) begin
      n_err++;
      $display("FAIL ce_pulse_width got=%0d cycles exp=1", pe_cnt);
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midcount();
    do_reset();
    ce = 1'b1; rise_en = 4'b0001; fall_en = '0; clr = '0;
    din = 4'b0001;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({pe, ne, ee, pend, irq} !== 17'd0) begin
      n_err++;
      $display("FAIL midcount_reset got=%h exp=0", {pe, ne, ee, pend, irq});
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_vec++;
      if (pe[0] !== (j == 6) || pend[0] !== (j >= 6)) begin
        n_err++;
        $display("FAIL midcount_relatch R+%0d got pe=%b pend=%b exp pe=%b", j, pe[0], pend[0], (j == 6));
      end
      n_vec++;
      if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL midcount_model R+%0d got=%h exp=%h", j, {pe, ne, ee, pend, irq},
                 {m_pe, m_ne, m_ee, m_pend, m_irq});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    din = '0;
    for (int j = 0; j < 600; j++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(7) == 0) din[c] = ~din[c];
      ce      = ($urandom_range(9) != 0);
      rise_en = W'($urandom);
      fall_en = W'($urandom);
      clr     = W'($urandom & $urandom);
      rst     = ($urandom_range(99) == 0);
      tick();
      n_vec++;
      if ({pe, ne, ee, pend, irq} !== {m_pe, m_ne, m_ee, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h exp=%h", j, {pe, ne, ee, pend, irq},
                 {m_pe, m_ne, m_ee, m_pend, m_irq});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < W; c++) m_run[c] = 0;
    #2;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_fall_disabled();
    test_clr_collision();
    test_ce_toggle();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
